// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width, default baud divisor.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  localparam int DATA_BITS            = 8;
  localparam int CLKS_PER_BIT_DEFAULT = 104;  // 12 MHz / 115200, also used by uart_tx

  // Two-out-of-three vote used to filter single-sample glitches.
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/sync_bit.sv
// N-flop synchronizer for one asynchronous input; resets to 1 so an idle-high
// line does not look like an edge when reset is released.
module sync_bit #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [N-1:0] ff;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk) begin
    if (reset) ff <= '1;
    else       ff <= {ff[N-2:0], d};
  end

  assign q = ff[N-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with false-start rejection, 3-sample majority voting per bit
// and framing-error detection followed by break recovery.
//
// state | meaning
// IDLE  | line idle, waiting for rxs low
// START | verifying start bit at mid-slot, rejecting glitches
// DATA  | receiving 8 data bits, LSB first
// STOP  | voting on the stop bit; leaves at mid-slot to absorb baud mismatch
// BREAK | stop bit was 0; wait for the line to return high
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic                 rx_valid,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CW  = $clog2(CLKS_PER_BIT);
  localparam int MID = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] SAMP_A   = CW'(MID - 1);
  localparam logic [CW-1:0] SAMP_B   = CW'(MID);
  localparam logic [CW-1:0] DECIDE   = CW'(MID + 1);
  localparam logic [2:0]    IDX_LAST = 3'(DATA_BITS - 1);

  state_t               state, state_nxt;
  logic [CW-1:0]        clk_cnt;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 rxs;
  logic                 s_a, s_b;
  logic                 maj, decide, last;
  logic                 load_bit, bit_inc, go_data, valid_set, ferr_set;

  sync_bit #(.N(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rxs)
  );

  assign decide = (clk_cnt == DECIDE);
  assign last   = (clk_cnt == CNT_LAST);
  assign maj    = majority3(s_a, s_b, rxs);
  assign busy   = (state != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode and datapath control strobes.
  always_comb begin
    state_nxt = state;
    load_bit  = 1'b0;
    bit_inc   = 1'b0;
    go_data   = 1'b0;
    valid_set = 1'b0;
    ferr_set  = 1'b0;
    case (state)
      IDLE: begin
        if (!rxs) state_nxt = START;
      end
      START: begin
        if (decide && maj) begin
          state_nxt = IDLE;
        end else if (last) begin
          state_nxt = DATA;
          go_data   = 1'b1;
        end
      end
      DATA: begin
        if (decide) load_bit = 1'b1;
        if (last) begin
          if (bit_idx == IDX_LAST) state_nxt = STOP;
          else                     bit_inc   = 1'b1;
        end
      end
      STOP: begin
        if (decide) begin
          if (maj) begin
            valid_set = 1'b1;
            state_nxt = IDLE;
          end else begin
            ferr_set  = 1'b1;
            state_nxt = BREAK;
          end
        end
      end
      BREAK: begin
        if (rxs) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bit-slot timer: restarts on every state change and at the end of each slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_cnt <= '0;
    end else if (state_nxt != state || last || state == IDLE || state == BREAK) begin
      clk_cnt <= '0;
    end else begin
      clk_cnt <= clk_cnt + 1'b1;
    end
  end

  // Capture the two early samples; the third is the live rxs at the decision point.
  always_ff @(posedge clk) begin
    if (reset) begin
      s_a <= 1'b1;
      s_b <= 1'b1;
    end else begin
      if (clk_cnt == SAMP_A) s_a <= rxs;
      if (clk_cnt == SAMP_B) s_b <= rxs;
    end
  end

  // Data bit index and shift register assembly.
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      if (go_data)      bit_idx <= '0;
      else if (bit_inc) bit_idx <= bit_idx + 1'b1;
      if (load_bit) shreg[bit_idx] <= maj;
    end
  end

  // Registered output strobes and the held data byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      rx_data   <= '0;
    end else begin
      rx_valid  <= valid_set;
      frame_err <= ferr_set;
      if (valid_set) rx_data <= shreg;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: frames are generated bit by bit from the 8N1 rules and
// the receiver's byte stream is compared with the list of bytes that were sent
// with a good stop bit.
module tb_uart_rx;

  localparam int BT = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       frame_err;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int ferr_cnt = 0;
  int both_cnt = 0;

  uart_rx #(.CLKS_PER_BIT(BT), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Output monitor: collect received bytes and strobe counts.
  always @(negedge clk) begin
    if (rx_valid) got_q.push_back(rx_data);
    if (frame_err) ferr_cnt++;
    if (rx_valid && frame_err) both_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  // Serial frame: start, 8 data bits LSB first, stop level held for stop_bits slots.
  task automatic send_frame(input logic [7:0] b, input int bt, input logic stop_v, input int stop_bits);
    hold(1'b0, bt);
    for (int i = 0; i < 8; i++) hold(b[i], bt);
    hold(stop_v, bt * stop_bits);
    rx = 1'b1;
    if (stop_v) exp_q.push_back(b);
  endtask

  task automatic clear_model();
    got_q.delete();
    exp_q.delete();
    ferr_cnt = 0;
  endtask

  task automatic compare_stream(input string name);
    n_checks++;
    if (got_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL %s_count: got %0d bytes, expected %0d", name, got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (got_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL %s_byte%0d: got %h expected %h", name, i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    n_checks += 4;
    if (rx_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_valid: got %b expected 0", rx_valid); end
    if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: got %b expected 0", frame_err); end
    if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    if (rx_data !== 8'h00)  begin n_fail++; $display("FAIL reset_data: got %h expected 00", rx_data); end
    reset = 1'b0;
    hold(1'b1, 10);
  endtask

  task automatic test_good_byte();
    int lat;
    clear_model();
    lat = 0;
    fork
      send_frame(8'hA5, BT, 1'b1, 1);
      begin
        while (!rx_valid && lat < 400) begin
          @(negedge clk);
          lat++;
        end
      end
    join
    hold(1'b1, 2 * BT);
    compare_stream("good");
    n_checks += 4;
    if (lat < 2 + 9 * BT + BT / 2 + 1 || lat > 2 + 9 * BT + BT / 2 + 3) begin
      n_fail++; $display("FAIL good_latency: got %0d cycles expected %0d +/-1", lat, 2 + 9 * BT + BT / 2 + 2);
    end
    if (rx_data !== 8'hA5) begin n_fail++; $display("FAIL good_data: got %h expected a5", rx_data); end
    if (ferr_cnt !== 0)    begin n_fail++; $display("FAIL good_ferr: got %0d expected 0", ferr_cnt); end
    if (busy !== 1'b0)     begin n_fail++; $display("FAIL good_busy: got %b expected 0", busy); end
  endtask

  task automatic test_false_start();
    clear_model();
    hold(1'b0, 4);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_high: got %b expected 1", busy); end
    hold(1'b1, 12);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_low: got %b expected 0", busy); end
    hold(1'b1, 2 * BT);
    compare_stream("glitch");
    n_checks++;
    if (ferr_cnt !== 0) begin n_fail++; $display("FAIL glitch_ferr: got %0d expected 0", ferr_cnt); end
  endtask

  task automatic test_frame_err();
    logic [7:0] b;
    clear_model();
    send_frame(8'hA5, BT, 1'b1, 1);
    hold(1'b1, 20);
    b = 8'h3C;
    hold(1'b0, BT);
    for (int i = 0; i < 8; i++) hold(b[i], BT);
    hold(1'b0, 2 * BT);
    n_checks += 3;
    if (ferr_cnt !== 1)    begin n_fail++; $display("FAIL ferr_pulse: got %0d expected 1", ferr_cnt); end
    if (rx_data !== 8'hA5) begin n_fail++; $display("FAIL ferr_data_hold: got %h expected a5", rx_data); end
    if (busy !== 1'b1)     begin n_fail++; $display("FAIL ferr_break_busy: got %b expected 1", busy); end
    hold(1'b0, BT);
    hold(1'b1, 20);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL ferr_recover: got %b expected 0", busy); end
    send_frame(8'h55, BT, 1'b1, 1);
    hold(1'b1, 2 * BT);
    compare_stream("ferr");
    n_checks += 2;
    if (ferr_cnt !== 1)    begin n_fail++; $display("FAIL ferr_total: got %0d expected 1", ferr_cnt); end
    if (rx_data !== 8'h55) begin n_fail++; $display("FAIL ferr_next_data: got %h expected 55", rx_data); end
  endtask

  task automatic test_back_to_back();
    clear_model();
    send_frame(8'h00, BT + 1, 1'b1, 1);
    send_frame(8'hFF, BT + 1, 1'b1, 1);
    hold(1'b1, 3 * BT);
    compare_stream("b2b");
    n_checks++;
    if (ferr_cnt !== 0) begin n_fail++; $display("FAIL b2b_ferr: got %0d expected 0", ferr_cnt); end
  endtask

  task automatic test_majority();
    logic [7:0] b;
    clear_model();
    b = 8'h81;
    hold(1'b0, BT);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        hold(1'b0, BT / 2);
        hold(1'b1, 1);
        hold(1'b0, BT / 2 - 1);
      end else begin
        hold(b[i], BT);
      end
    end
    hold(1'b1, BT);
    exp_q.push_back(b);
    hold(1'b1, 2 * BT);
    compare_stream("vote");
    n_checks++;
    if (rx_data !== 8'h81) begin n_fail++; $display("FAIL vote_data: got %h expected 81", rx_data); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b;
    clear_model();
    b = 8'h5A;
    hold(1'b0, BT);
    for (int i = 0; i < 5; i++) hold(b[i], BT);
    rx    = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    hold(1'b1, 12 * BT);
    n_checks += 4;
    if (got_q.size() !== 0) begin n_fail++; $display("FAIL rst_no_valid: got %0d bytes expected 0", got_q.size()); end
    if (ferr_cnt !== 0)     begin n_fail++; $display("FAIL rst_no_ferr: got %0d expected 0", ferr_cnt); end
    if (rx_data !== 8'h00)  begin n_fail++; $display("FAIL rst_data: got %h expected 00", rx_data); end
    if (busy !== 1'b0)      begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
    send_frame(8'hC3, BT, 1'b1, 1);
    hold(1'b1, 2 * BT);
    compare_stream("rst");
    n_checks++;
    if (rx_data !== 8'hC3) begin n_fail++; $display("FAIL rst_next_data: got %h expected c3", rx_data); end
  endtask

  task automatic test_random();
    int exp_ferr;
    logic [7:0] b;
    clear_model();
    exp_ferr = 0;
    for (int k = 0; k < 16; k++) begin
      b = 8'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        send_frame(b, BT, 1'b1, 1);
      end else begin
        send_frame(b, BT, 1'b0, 2);
        exp_ferr++;
      end
      hold(1'b1, $urandom_range(1, 20));
    end
    hold(1'b1, 3 * BT);
    compare_stream("rand");
    n_checks++;
    if (ferr_cnt !== exp_ferr) begin n_fail++; $display("FAIL rand_ferr: got %0d expected %0d", ferr_cnt, exp_ferr); end
  endtask

  initial begin
    reset = 1'b1;
    rx    = 1'b1;
    @(negedge clk);
    test_reset();
    test_good_byte();
    test_false_start();
    test_frame_err();
    test_back_to_back();
    test_majority();
    test_reset_mid_frame();
    test_random();
    n_checks++;
    if (both_cnt !== 0) begin n_fail++; $display("FAIL exclusive: got %0d overlapping cycles expected 0", both_cnt); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
